// File: rtl/pl_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects
// and the multi-cycle execute-unit state type.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

endpackage

// File: rtl/pl_hazard_ctrl_md_busy_ctr.sv
// Multi-cycle execute-unit occupancy tracker: MdBusy is high for exactly
// MD_LAT cycles starting combinationally in the cycle MdStartE is seen in IDLE.
module md_busy_ctr
  import hazard_pkg::*;
#(
  parameter int MD_LAT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic MdStartE,
  output logic MdBusy
);

  localparam int CW = $clog2(MD_LAT);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MD_LAT - 2);

  md_state_t     state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= MD_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // The start cycle counts as the first busy cycle, hence the MD_LAT-2 preload.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    MdBusy     = 1'b0;
    case (state_reg)
      MD_IDLE: begin
        if (MdStartE) begin
          state_next = MD_BUSY;
          cnt_next   = CNT_LOAD;
          MdBusy     = 1'b1;
        end
      end
      MD_BUSY: begin
        MdBusy = 1'b1;
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end else begin
          state_next = MD_IDLE;
        end
      end
      default: begin
        state_next = MD_IDLE;
        cnt_next   = '0;
      end
    endcase
    if (!reset) begin
      MdBusy = 1'b0;
    end
  end

endmodule

// File: rtl/pl_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage RISC-V pipeline.
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined.
module pl_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int MD_LAT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs1D,
  input  logic [REG_AW-1:0] rs2D,
  input  logic [REG_AW-1:0] rs1E,
  input  logic [REG_AW-1:0] rs2E,
  input  logic [REG_AW-1:0] rdE,
  input  logic [REG_AW-1:0] rdM,
  input  logic [REG_AW-1:0] rdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              LoadE,
  input  logic              PCSrcE,
  input  logic              MdStartE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              StallW,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              FlushW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              MdBusy,
  output logic [31:0]       StallCnt,
  output logic [31:0]       FlushCnt
);

  logic startup_reg;
  logic hold;
  logic lw_stall;
  logic md_start;
  logic md_busy;

  // Stays set through reset and for one cycle after release, so D starts clean.
  always_ff @(posedge clk) begin
    if (!reset) begin
      startup_reg <= 1'b1;
    end else begin
      startup_reg <= 1'b0;
    end
  end

  assign hold     = !reset || startup_reg;
  assign md_start = MdStartE && !startup_reg;

  md_busy_ctr #(
    .MD_LAT (MD_LAT)
  ) u_md_busy_ctr (
    .clk      (clk),
    .reset    (reset),
    .MdStartE (md_start),
    .MdBusy   (md_busy)
  );

  assign MdBusy = md_busy;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic [REG_AW-1:0] rs;
      logic [1:0]        sel;

      assign rs = (gi == 0) ? rs1E : rs2E;

      // Memory stage holds the younger result, so it wins over writeback.
      always_comb begin
        sel = FWD_RF;
        if (RegWriteM && (rdM != '0) && (rdM == rs)) begin
          sel = FWD_MEM;
        end else if (RegWriteW && (rdW != '0) && (rdW == rs)) begin
          sel = FWD_WB;
        end
        if (!reset) begin
          sel = FWD_RF;
        end
      end
    end
  endgenerate

  assign ForwardAE = g_fwd[0].sel;
  assign ForwardBE = g_fwd[1].sel;

  assign lw_stall = LoadE && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));

  // Priority: reset/startup bubble, then multi-cycle busy, then redirect, then load-use.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    FlushW = 1'b0;
    if (hold) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushM = 1'b1;
      FlushW = 1'b1;
    end else if (md_busy) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lw_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  assign StallM = 1'b0;
  assign StallW = 1'b0;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] flush_cnt_reg;
  logic        redirect_flush;

  assign redirect_flush = !hold && !md_busy && PCSrcE;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (StallF && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
      if (redirect_flush && (flush_cnt_reg != 32'hFFFF_FFFF)) begin
        flush_cnt_reg <= flush_cnt_reg + 32'd1;
      end
    end
  end

  assign StallCnt = stall_cnt_reg;
  assign FlushCnt = flush_cnt_reg;
`else
  assign StallCnt = 32'd0;
  assign FlushCnt = 32'd0;
`endif

endmodule

// File: tb/tb_pl_hazard_ctrl.sv
// Directed self-checking bench for pl_hazard_ctrl (MD_LAT=4, REG_AW=5).
module tb_pl_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic       RegWriteM, RegWriteW, LoadE, PCSrcE, MdStartE;
  logic       StallF, StallD, StallE, StallM, StallW;
  logic       FlushD, FlushE, FlushM, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic       MdBusy;
  logic [31:0] StallCnt, FlushCnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pl_hazard_ctrl #(
    .REG_AW (5),
    .MD_LAT (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rs1D      (rs1D),
    .rs2D      (rs2D),
    .rs1E      (rs1E),
    .rs2E      (rs2E),
    .rdE       (rdE),
    .rdM       (rdM),
    .rdW       (rdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .LoadE     (LoadE),
    .PCSrcE    (PCSrcE),
    .MdStartE  (MdStartE),
    .StallF    (StallF),
    .StallD    (StallD),
    .StallE    (StallE),
    .StallM    (StallM),
    .StallW    (StallW),
    .FlushD    (FlushD),
    .FlushE    (FlushE),
    .FlushM    (FlushM),
    .FlushW    (FlushW),
    .ForwardAE (ForwardAE),
    .ForwardBE (ForwardBE),
    .MdBusy    (MdBusy),
    .StallCnt  (StallCnt),
    .FlushCnt  (FlushCnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    rs1D = '0; rs2D = '0; rs1E = '0; rs2E = '0;
    rdE = '0; rdM = '0; rdW = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0;
    LoadE = 1'b0; PCSrcE = 1'b0; MdStartE = 1'b0;
  endtask

  // stall vector {F,D,E,M,W}, flush vector {D,E,M,W}
  task automatic check_ctrl(input string tag, input logic [4:0] st, input logic [3:0] fl);
    #1;
    check_eq({tag, ".stall"}, {27'd0, StallF, StallD, StallE, StallM, StallW}, {27'd0, st});
    check_eq({tag, ".flush"}, {28'd0, FlushD, FlushE, FlushM, FlushW}, {28'd0, fl});
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;

    // Reset: forwarding forced to RF even with a matching producer
    rs1E = 5'd5; rs2E = 5'd5; rdM = 5'd5; RegWriteM = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      check_ctrl($sformatf("rst%0d", i), 5'b00000, 4'b1111);
      check_eq($sformatf("rst%0d.fwdA", i), {30'd0, ForwardAE}, 32'd0);
      check_eq($sformatf("rst%0d.busy", i), {31'd0, MdBusy}, 32'd0);
    end
    next_cycle();
    clear_inputs();
    reset = 1'b1;
    check_ctrl("startup", 5'b00000, 4'b1111);
    next_cycle();
    check_ctrl("post_startup", 5'b00000, 4'b0000);

    // Forwarding on rs1E then rs2E
    next_cycle();
    rs1E = 5'd5; rdM = 5'd5; RegWriteM = 1'b1; rdW = 5'd5; RegWriteW = 1'b1;
    #1 check_eq("fwdA.mem", {30'd0, ForwardAE}, 32'd2);
    RegWriteM = 1'b0;
    #1 check_eq("fwdA.wb", {30'd0, ForwardAE}, 32'd1);
    rdM = 5'd0; rdW = 5'd0; RegWriteM = 1'b1;
    #1 check_eq("fwdA.x0", {30'd0, ForwardAE}, 32'd0);
    clear_inputs();
    rs2E = 5'd9; rdM = 5'd9; RegWriteM = 1'b1; rdW = 5'd9; RegWriteW = 1'b1;
    #1 check_eq("fwdB.mem", {30'd0, ForwardBE}, 32'd2);
    check_eq("fwdB.A_rf", {30'd0, ForwardAE}, 32'd0);
    RegWriteM = 1'b0;
    #1 check_eq("fwdB.wb", {30'd0, ForwardBE}, 32'd1);
    rdM = 5'd0; rdW = 5'd0; RegWriteM = 1'b1;
    #1 check_eq("fwdB.x0", {30'd0, ForwardBE}, 32'd0);

    // Load-use: one cycle, then the load has left E
    next_cycle();
    clear_inputs();
    LoadE = 1'b1; rdE = 5'd7; rs2D = 5'd7;
    check_ctrl("lw.hit", 5'b11000, 4'b0100);
    next_cycle();
    LoadE = 1'b0; rdE = 5'd0;
    check_ctrl("lw.after", 5'b00000, 4'b0000);
    next_cycle();
    LoadE = 1'b1; rdE = 5'd0; rs1D = 5'd0; rs2D = 5'd0;
    check_ctrl("lw.x0", 5'b00000, 4'b0000);

    // Redirect overrides load-use
    next_cycle();
    clear_inputs();
    LoadE = 1'b1; rdE = 5'd3; rs1D = 5'd3; PCSrcE = 1'b1;
    check_ctrl("redir_lw", 5'b00000, 4'b1100);

    // Multi-cycle op: 4 busy cycles, redirect masked until release
    next_cycle();
    clear_inputs();
    MdStartE = 1'b1;
    #1 check_eq("md.c0.busy", {31'd0, MdBusy}, 32'd1);
    check_ctrl("md.c0", 5'b11100, 4'b0010);
    for (int c = 1; c < 4; c++) begin
      next_cycle();
      MdStartE = 1'b0;
      PCSrcE = 1'b1;
      LoadE = 1'b1; rdE = 5'd4; rs1D = 5'd4;
      #1 check_eq($sformatf("md.c%0d.busy", c), {31'd0, MdBusy}, 32'd1);
      check_ctrl($sformatf("md.c%0d", c), 5'b11100, 4'b0010);
    end
    next_cycle();
    #1 check_eq("md.rel.busy", {31'd0, MdBusy}, 32'd0);
    check_ctrl("md.rel", 5'b00000, 4'b1100);
    next_cycle();
    clear_inputs();
    check_ctrl("md.idle", 5'b00000, 4'b0000);

    // Reset in the second busy cycle
    next_cycle();
    MdStartE = 1'b1;
    next_cycle();
    MdStartE = 1'b0;
    #1 check_eq("mdrst.c1.busy", {31'd0, MdBusy}, 32'd1);
    reset = 1'b0;
    #1 check_eq("mdrst.inrst.busy", {31'd0, MdBusy}, 32'd0);
    check_ctrl("mdrst.inrst", 5'b00000, 4'b1111);
    next_cycle();
    reset = 1'b1;
    #1 check_eq("mdrst.after.busy", {31'd0, MdBusy}, 32'd0);
    check_ctrl("mdrst.startup", 5'b00000, 4'b1111);
    next_cycle();
    check_ctrl("mdrst.clean", 5'b00000, 4'b0000);

    // Performance counters: 10 load-use stalls then 3 redirects
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      LoadE = 1'b1; rdE = 5'd6; rs1D = 5'd6;
    end
    next_cycle();
    clear_inputs();
    PCSrcE = 1'b1;
`ifdef HAZ_PERF_CNT_EN
    #1 check_eq("perf.stall", StallCnt, 32'd10);
`else
    #1 check_eq("perf.stall", StallCnt, 32'd0);
`endif
    next_cycle();
    next_cycle();
    next_cycle();
    clear_inputs();
`ifdef HAZ_PERF_CNT_EN
    #1 check_eq("perf.flush", FlushCnt, 32'd3);
    check_eq("perf.stall_hold", StallCnt, 32'd10);
`else
    #1 check_eq("perf.flush", FlushCnt, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
